// File: rtl/mem_write_stride_sequencer.sv
// mem_write_stride_sequencer: strided write-command and address-derived payload generator for an AXI4 write master
module mem_write_stride_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH     = 64,
  parameter int C_AXIS_TDATA_WIDTH     = 256,
  parameter int C_XFER_SIZE_WIDTH      = 32,
  parameter int ADDRESS_INCREMENT_SIZE = 32,
  parameter int MEM_ADDR_SIZE          = 32
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     base_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]      xfer_bytes,
  input  logic [ADDRESS_INCREMENT_SIZE-1:0] addr_increment,
  input  logic [MEM_ADDR_SIZE-1:0]          mem_max_addr,
  output logic                              done,
  output logic [31:0]                       cmd_count,
  output logic                              write_out_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     write_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]      out_data_size,
  output logic                              out_data_valid,
  input  logic                              out_data_ready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     out_data,
  input  logic                              write_done
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int XW = C_XFER_SIZE_WIDTH;
  localparam int TW = C_AXIS_TDATA_WIDTH;
  localparam int DW = TW / 8;
  localparam int NL = TW / 32;
  typedef enum logic [2:0] {IDLE, ISSUE, STREAM, WAIT_DONE, FINISH} state_t;
  state_t                            state_q;
  logic [AW-1:0]                     base_q;
  logic [XW-1:0]                     xfer_q;
  logic [ADDRESS_INCREMENT_SIZE-1:0] inc_q;
  logic [MEM_ADDR_SIZE-1:0]          max_q;
  logic [63:0]                       offset_q;
  logic [XW-1:0]                     rem_q;
  logic [31:0]                       baddr_q;
  logic                              wd_q;
  logic                              done_q;
  logic [31:0]                       cmd_count_q;
  logic                              write_out_data_q;
  logic [AW-1:0]                     write_addr_q;
  logic [XW-1:0]                     out_data_size_q;
  logic                              out_data_valid_q;
  logic [TW-1:0]                     out_data_q;
  logic [63:0]                       offset_d;
  logic                              fits_d;
  assign done           = done_q;
  assign cmd_count      = cmd_count_q;
  assign write_out_data = write_out_data_q;
  assign write_addr     = write_addr_q;
  assign out_data_size  = out_data_size_q;
  assign out_data_valid = out_data_valid_q;
  assign out_data       = out_data_q;
  // 64-bit offset math: offset and stride are at most 32 bits wide, so the sum cannot wrap
  assign offset_d = offset_q + 64'(inc_q);
  assign fits_d   = (offset_d + 64'(xfer_q)) <= 64'(max_q);
  // Each 32-bit lane carries the low 32 bits of its own byte address
  function automatic logic [TW-1:0] lanes(input logic [31:0] a);
    logic [TW-1:0] d;
    for (int k = 0; k < NL; k++) d[32*k +: 32] = a + 32'(4 * k);
    return d;
  endfunction
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q          <= IDLE;
      base_q           <= '0;
      xfer_q           <= '0;
      inc_q            <= '0;
      max_q            <= '0;
      offset_q         <= '0;
      rem_q            <= '0;
      baddr_q          <= '0;
      wd_q             <= 1'b0;
      done_q           <= 1'b0;
      cmd_count_q      <= '0;
      write_out_data_q <= 1'b0;
      write_addr_q     <= '0;
      out_data_size_q  <= '0;
      out_data_valid_q <= 1'b0;
      out_data_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          base_q   <= base_addr;
          xfer_q   <= xfer_bytes;
          inc_q    <= addr_increment;
          max_q    <= mem_max_addr;
          offset_q <= '0;
          wd_q     <= 1'b0;
          if (xfer_bytes == '0 || 64'(xfer_bytes) > 64'(mem_max_addr)) begin
            cmd_count_q <= '0;
            done_q      <= 1'b1;
            state_q     <= FINISH;
          end else begin
            cmd_count_q      <= 32'd1;
            write_out_data_q <= 1'b1;
            write_addr_q     <= base_addr;
            out_data_size_q  <= xfer_bytes;
            state_q          <= ISSUE;
          end
        end
        ISSUE: begin
          write_out_data_q <= 1'b0;
          out_data_valid_q <= 1'b1;
          out_data_q       <= lanes(write_addr_q[31:0]);
          baddr_q          <= write_addr_q[31:0] + 32'(DW);
          rem_q            <= xfer_q;
          if (write_done) wd_q <= 1'b1;
          state_q          <= STREAM;
        end
        STREAM: begin
          // A completion arriving before the last beat is held for WAIT_DONE
          if (write_done) wd_q <= 1'b1;
          if (out_data_valid_q && out_data_ready) begin
            if (rem_q <= XW'(DW)) begin
              out_data_valid_q <= 1'b0;
              state_q          <= WAIT_DONE;
            end else begin
              rem_q      <= rem_q - XW'(DW);
              out_data_q <= lanes(baddr_q);
              baddr_q    <= baddr_q + 32'(DW);
            end
          end
        end
        WAIT_DONE: if (write_done || wd_q) begin
          wd_q <= 1'b0;
          if (inc_q == '0 || !fits_d) begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            offset_q         <= offset_d;
            write_out_data_q <= 1'b1;
            write_addr_q     <= base_q + AW'(offset_d);
            cmd_count_q      <= cmd_count_q + 32'd1;
            state_q          <= ISSUE;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_write_stride_sequencer.sv
// tb_mem_write_stride_sequencer: directed self-checking bench for mem_write_stride_sequencer
module tb_mem_write_stride_sequencer;
  logic         aclk;
  logic         areset;
  logic         start;
  logic [63:0]  base_addr;
  logic [31:0]  xfer_bytes;
  logic [31:0]  addr_increment;
  logic [31:0]  mem_max_addr;
  logic         done;
  logic [31:0]  cmd_count;
  logic         write_out_data;
  logic [63:0]  write_addr;
  logic [31:0]  out_data_size;
  logic         out_data_valid;
  logic         out_data_ready;
  logic [255:0] out_data;
  logic         write_done;
  int n_chk;
  int n_err;
  logic [63:0]  cmds[$];
  logic [31:0]  sizes[$];
  logic [255:0] beats[$];
  int first_wo;
  int first_valid;
  int done_cyc;
  logic [31:0] cc_first;
  mem_write_stride_sequencer dut (
    .aclk(aclk), .areset(areset), .start(start), .base_addr(base_addr),
    .xfer_bytes(xfer_bytes), .addr_increment(addr_increment), .mem_max_addr(mem_max_addr),
    .done(done), .cmd_count(cmd_count), .write_out_data(write_out_data),
    .write_addr(write_addr), .out_data_size(out_data_size), .out_data_valid(out_data_valid),
    .out_data_ready(out_data_ready), .out_data(out_data), .write_done(write_done)
  );
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  task automatic tick;
    @(posedge aclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"}, 256'(done), 0);
    chk({tag, "_wod"}, 256'(write_out_data), 0);
    chk({tag, "_valid"}, 256'(out_data_valid), 0);
    chk({tag, "_cnt"}, 256'(cmd_count), 0);
    chk({tag, "_addr"}, 256'(write_addr), 0);
    chk({tag, "_size"}, 256'(out_data_size), 0);
    chk({tag, "_data"}, out_data, 0);
  endtask
  task automatic run(input logic [63:0] b, input logic [31:0] x, input logic [31:0] inc,
                     input logic [31:0] m, input bit bp, input bit early);
    int per;
    int bpc;
    bit wd_next;
    bit stalled;
    bit got_done;
    logic [255:0] held;
    cmds.delete();
    sizes.delete();
    beats.delete();
    first_wo = 0;
    first_valid = 0;
    done_cyc = 0;
    cc_first = '0;
    per = 0;
    bpc = int'((x + 32'd31) / 32'd32);
    wd_next = 0;
    stalled = 0;
    got_done = 0;
    held = '0;
    base_addr = b;
    xfer_bytes = x;
    addr_increment = inc;
    mem_max_addr = m;
    out_data_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 600 && !got_done; c++) begin
      write_done = wd_next;
      wd_next = 0;
      out_data_ready = bp ? c[0] : 1'b1;
      if (write_out_data) begin
        cmds.push_back(write_addr);
        sizes.push_back(out_data_size);
        if (first_wo == 0) begin
          first_wo = c;
          cc_first = cmd_count;
        end
      end
      if (out_data_valid) begin
        if (first_valid == 0) first_valid = c;
        if (stalled) chk("hold", out_data, held);
        if (out_data_ready) begin
          beats.push_back(out_data);
          stalled = 0;
          per++;
          if (per == bpc) begin
            per = 0;
            if (early) write_done = 1'b1;
            else wd_next = 1;
          end
        end else begin
          stalled = 1;
          held = out_data;
        end
      end
      if (done) begin
        got_done = 1;
        done_cyc = c;
      end
      tick;
    end
    write_done = 1'b0;
    chk("timeout", 256'(got_done), 1);
    chk("done_pulse", 256'(done), 0);
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    areset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    xfer_bytes = '0;
    addr_increment = '0;
    mem_max_addr = '0;
    out_data_ready = 1'b0;
    write_done = 1'b0;
    tick;
    tick;
    areset = 1'b0;
    tick;
    chk_idle_outputs("rst");
    // basic walk
    run(64'h1000, 64, 64, 256, 0, 0);
    chk("walk_ncmd", 256'(cmds.size()), 4);
    chk("walk_a0", 256'(cmds[0]), 256'h1000);
    chk("walk_a1", 256'(cmds[1]), 256'h1040);
    chk("walk_a2", 256'(cmds[2]), 256'h1080);
    chk("walk_a3", 256'(cmds[3]), 256'h10C0);
    chk("walk_size", 256'(sizes[0]), 64);
    chk("walk_nbeat", 256'(beats.size()), 8);
    chk("walk_b0l0", 256'(beats[0][31:0]), 256'h1000);
    chk("walk_b0l7", 256'(beats[0][255:224]), 256'h101C);
    chk("walk_b1l0", 256'(beats[1][31:0]), 256'h1020);
    chk("walk_b2l0", 256'(beats[2][31:0]), 256'h1040);
    chk("walk_b7l7", 256'(beats[7][255:224]), 256'h10FC);
    chk("walk_cnt", 256'(cmd_count), 4);
    chk("walk_lat_wo", 256'(first_wo), 1);
    chk("walk_lat_v", 256'(first_valid), 2);
    // partial final beat
    run(64'h2000, 40, 128, 128, 0, 0);
    chk("part_ncmd", 256'(cmds.size()), 1);
    chk("part_size", 256'(sizes[0]), 40);
    chk("part_nbeat", 256'(beats.size()), 2);
    chk("part_b1l0", 256'(beats[1][31:0]), 256'h2020);
    chk("part_b1l7", 256'(beats[1][255:224]), 256'h203C);
    chk("part_cnt", 256'(cmd_count), 1);
    // backpressure
    run(64'h3000, 128, 128, 128, 1, 0);
    chk("bp_ncmd", 256'(cmds.size()), 1);
    chk("bp_nbeat", 256'(beats.size()), 4);
    chk("bp_b0l0", 256'(beats[0][31:0]), 256'h3000);
    chk("bp_b1l0", 256'(beats[1][31:0]), 256'h3020);
    chk("bp_b2l0", 256'(beats[2][31:0]), 256'h3040);
    chk("bp_b3l7", 256'(beats[3][255:224]), 256'h307C);
    // degenerate: zero bytes, oversize, zero stride
    run(64'h6000, 0, 64, 256, 0, 0);
    chk("zero_ncmd", 256'(cmds.size()), 0);
    chk("zero_lat", 256'(done_cyc), 1);
    chk("zero_cnt", 256'(cmd_count), 0);
    run(64'h6000, 512, 64, 256, 0, 0);
    chk("big_ncmd", 256'(cmds.size()), 0);
    chk("big_lat", 256'(done_cyc), 1);
    chk("big_cnt", 256'(cmd_count), 0);
    run(64'h7000, 64, 0, 256, 0, 0);
    chk("inc0_ncmd", 256'(cmds.size()), 1);
    chk("inc0_cnt", 256'(cmd_count), 1);
    // completion arriving with the last beat
    run(64'h4000, 64, 64, 128, 0, 1);
    chk("early_ncmd", 256'(cmds.size()), 2);
    chk("early_a1", 256'(cmds[1]), 256'h4040);
    chk("early_cnt", 256'(cmd_count), 2);
    // reset mid-stream after one of four beats
    base_addr = 64'h5000;
    xfer_bytes = 128;
    addr_increment = 128;
    mem_max_addr = 256;
    out_data_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("mid_valid", 256'(out_data_valid), 1);
    areset = 1'b1;
    tick;
    chk_idle_outputs("mid");
    areset = 1'b0;
    tick;
    run(64'h5000, 128, 128, 256, 0, 0);
    chk("re_ncmd", 256'(cmds.size()), 2);
    chk("re_a0", 256'(cmds[0]), 256'h5000);
    chk("re_a1", 256'(cmds[1]), 256'h5080);
    chk("re_cc1", 256'(cc_first), 1);
    chk("re_nbeat", 256'(beats.size()), 8);
    chk("re_b0l0", 256'(beats[0][31:0]), 256'h5000);
    chk("re_b4l0", 256'(beats[4][31:0]), 256'h5080);
    chk("re_cnt", 256'(cmd_count), 2);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
